mem_refill_ctrl: RTL
====================

Name: mem_refill_ctrl

Overview:
- Cache-side initiator for the memory request interface (mem_req / mem_addr / mem_ready / mem_data) that the memory model answers.
- Accepts one I-cache miss at a time, aligns the address to a 128-bit line, and issues a level-held memory request.
- Captures the returned line and hands it to the cache fill path through a valid/ready handshake.
- Adds a request timeout and a minimum inter-request gap, so a stalled or slow memory model cannot hang the cache.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, line / memory data width; must be a power of two and at least 8.
- TIMEOUT, 64, maximum REQ cycles before abort; 0 disables the timeout.
- GAP_CYCLES, 1, idle cycles forced with mem_req low after every transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_valid  in  1  cache presents a miss.
- miss_ready  out  1  controller can accept a miss.
- miss_addr  in  ADDR_W  byte address of the miss.
- fill_valid  out  1  line (or error) available.
- fill_ready  in  1  cache consumes the fill.
- fill_addr  out  ADDR_W  line-aligned address of the fill.
- fill_data  out  LINE_W  returned line.
- fill_err  out  1  fill ended by timeout; fill_data is zero.
- mem_req  out  1  memory request, level-held.
- mem_addr  out  ADDR_W  line-aligned request address.
- mem_ready  in  1  memory response strobe.
- mem_data  in  LINE_W  memory response data, valid with mem_ready.
- busy  out  1  state is not IDLE.

Behaviour:
- OFF = log2(LINE_W/8). Aligned address = miss_addr with bits [OFF-1:0] cleared.
- All outputs are registered except miss_ready (state==IDLE) and busy (state!=IDLE).
- Reset values: state IDLE; mem_req 0; mem_addr 0; fill_valid 0; fill_err 0; fill_addr 0; fill_data 0. miss_ready reads 1 once reset is released.
- States: IDLE, REQ, RESP, GAP.
- IDLE:
  - miss_valid && miss_ready at edge N: latch the aligned address into mem_addr and fill_addr; set mem_req=1; clear the timer; go to REQ.
  - mem_req is visible high in cycle N+1.
- REQ:
  - mem_req=1; mem_addr stays constant; the timer increments each cycle.
  - mem_ready sampled 1: capture mem_data into fill_data; set fill_err=0; set mem_req=0; set fill_valid=1; go to RESP. Minimum miss-accept to fill_valid latency is 2 cycles.
  - Timer reaches TIMEOUT-1 with mem_ready 0 (TIMEOUT>0): set mem_req=0; fill_data=0; fill_err=1; fill_valid=1; go to RESP.
  - mem_ready on the same edge as timeout expiry: the data response wins and fill_err=0.
- RESP:
  - fill_valid, fill_addr, fill_data and fill_err stay stable until fill_ready.
  - On the fill_valid && fill_ready edge: fill_valid=0; go to GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - mem_req=0; count GAP_CYCLES cycles, then go to IDLE.
  - Back-to-back requests therefore see mem_req low for at least GAP_CYCLES+1 cycles.
- mem_ready outside REQ is ignored: no capture, no state change.
- miss_valid outside IDLE is not accepted; miss_ready is 0.
- Timer width is clog2(TIMEOUT+1); it saturates and never wraps.
- rst_n asserted mid-transaction: mem_req and fill_valid drop immediately (asynchronous); the transaction is abandoned with no fill; the next miss is accepted after release.
- A fill_ready that was already high when fill_valid rises completes the handshake in that first RESP cycle.

Decomposition:
- Package mem_if_pkg:
  - refill_state_e enum (IDLE, REQ, RESP, GAP).
  - LINE_BYTES and OFF_BITS constants.
  - mem_req_t struct {req, addr}.
  - Shared later with the memory model and the cache top.
- Sub-module mem_req_timer: saturating timeout counter with clear/enable and an expire flag. Everything else lives in a single FSM module.

Test Plan:
- Basic fill: miss_addr=0x1234_567B, memory answers 3 cycles after mem_req -> mem_addr=0x1234_5670 held for 3 cycles; fill_valid with fill_addr=0x1234_5670, fill_data equal to the driven pattern, fill_err=0.
- Timeout: TIMEOUT=8, memory never answers -> mem_req high for exactly 8 cycles, then fill_valid with fill_err=1 and fill_data=0.
- Race: mem_ready asserted on the timeout-expiry edge -> fill_err=0 and data captured.
- Backpressure and gap: fill_ready held low 5 cycles, second miss pending -> fill outputs stable for 5 cycles, miss_ready 0; second mem_req rises no earlier than GAP_CYCLES+1 cycles after fill accept.
- Spurious response: mem_ready pulsed in IDLE and in GAP -> no fill_valid and no state change.
- Reset mid-REQ: rst_n low 2 cycles during REQ -> mem_req 0 immediately; no fill issued; a new miss after release completes normally.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache <-> memory request interface.
package mem_if_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned LINE_BYTES = LINE_W_DEF / 8;
  localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StGap
  } refill_state_e;

  typedef struct packed {
    logic                  req;
    logic [ADDR_W_DEF-1:0] addr;
  } mem_req_t;

  // Number of byte-offset bits inside a line of line_w bits.
  function automatic int unsigned off_bits(int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Saturating request timer; expire_o flags the last allowed REQ cycle.
module mem_req_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          Enabled = (TIMEOUT > 0);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = Enabled && (cnt_q == CntLast);

endmodule

// File: rtl/mem_refill_ctrl.sv
// I-cache line refill initiator: one miss at a time, level-held memory request,
// timeout abort, valid/ready fill handoff and a forced idle gap afterwards.
module mem_refill_ctrl
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [ADDR_W-1:0] miss_addr_i,
  output logic              fill_valid_o,
  input  logic              fill_ready_i,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic              fill_err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o
);

  localparam int unsigned OffW = off_bits(LINE_W);
  localparam logic [ADDR_W-1:0] AlignMask = {ADDR_W{1'b1}} << OffW;
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  refill_state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0] fill_data_q, fill_data_d;
  logic              fill_err_q, fill_err_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;

  logic tmr_clr, tmr_en, tmr_expire;

  mem_req_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a data response takes priority over timeout expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (miss_valid_i) state_d = StReq;
      StReq:  if (mem_ready_i || tmr_expire) state_d = StResp;
      StResp: if (fill_ready_i) state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
      StGap:  if (gap_cnt_q == GapLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, timer control and gap counter.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_valid_d = fill_valid_q;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    fill_err_d   = fill_err_q;
    gap_cnt_d    = gap_cnt_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss_valid_i) begin
          mem_addr_d  = miss_addr_i & AlignMask;
          fill_addr_d = miss_addr_i & AlignMask;
          mem_req_d   = 1'b1;
          tmr_clr     = 1'b1;
        end
      end
      StReq: begin
        tmr_en = 1'b1;
        if (mem_ready_i) begin
          fill_data_d  = mem_data_i;
          fill_err_d   = 1'b0;
          mem_req_d    = 1'b0;
          fill_valid_d = 1'b1;
        end else if (tmr_expire) begin
          fill_data_d  = '0;
          fill_err_d   = 1'b1;
          mem_req_d    = 1'b0;
          fill_valid_d = 1'b1;
        end
      end
      StResp: begin
        if (fill_ready_i) begin
          fill_valid_d = 1'b0;
          gap_cnt_d    = '0;
        end
      end
      StGap: gap_cnt_d = gap_cnt_q + GapW'(1);
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_err_q   <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      fill_err_q   <= fill_err_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign miss_ready_o = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign fill_valid_o = fill_valid_q;
  assign fill_addr_o  = fill_addr_q;
  assign fill_data_o  = fill_data_q;
  assign fill_err_o   = fill_err_q;

endmodule
